// File: rtl/writeback_unit.sv
// writeback_unit: commits execute results to the VM register file and drains queued stores to data memory.
// Optional WB_BYPASS_EN forwards the register value being written to the read ports in the same cycle.
module writeback_unit #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int REG_AW    = 8,
    parameter int STQ_DEPTH = 4,
    parameter int STQ_AW    = 2
) (
    input  logic              clk_ex,
    input  logic              n_reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              reg_we,
    input  logic [REG_AW-1:0] reg_id,
    input  logic [DATA_W-1:0] reg_val,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_val,
    input  logic [REG_AW-1:0] rd_id_a,
    input  logic [REG_AW-1:0] rd_id_b,
    output logic [DATA_W-1:0] rd_val_a,
    output logic [DATA_W-1:0] rd_val_b,
    output logic              dmem_req,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    output logic              stq_empty
);
    localparam logic [STQ_AW:0] FULL = (STQ_AW+1)'(STQ_DEPTH);
    localparam logic [STQ_AW:0] ONE  = (STQ_AW+1)'(1);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] rf_q [2**REG_AW];
    logic [ADDR_W-1:0] stq_addr_q [STQ_DEPTH];
    logic [DATA_W-1:0] stq_data_q [STQ_DEPTH];
    logic [STQ_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [STQ_AW:0]   count_q, count_d;
    logic              accept, push, pop;

    assign ex_ready  = count_q != FULL;
    assign accept    = ex_valid & ex_ready;
    assign push      = accept & mem_we;
    assign pop       = (state_q == S_REQ) & dmem_ack;
    assign rd_nxt    = rd_ptr_q + STQ_AW'(1);
    assign stq_empty = (count_q == '0) & ~dmem_req;

`ifdef WB_BYPASS_EN
    assign rd_val_a = (accept & reg_we & (rd_id_a == reg_id)) ? reg_val : rf_q[rd_id_a];
    assign rd_val_b = (accept & reg_we & (rd_id_b == reg_id)) ? reg_val : rf_q[rd_id_b];
`else
    assign rd_val_a = rf_q[rd_id_a];
    assign rd_val_b = rf_q[rd_id_b];
`endif

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + STQ_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_nxt : rd_ptr_q;
        count_d  = count_q + (STQ_AW+1)'(push) - (STQ_AW+1)'(pop);
    end

    always_ff @(posedge clk_ex) begin
        if (accept & reg_we)
            rf_q[reg_id] <= reg_val;
        if (push) begin
            stq_addr_q[wr_ptr_q] <= mem_addr;
            stq_data_q[wr_ptr_q] <= mem_val;
        end
    end

    // The in-flight store stays counted until acked, so count>1 means another entry is waiting.
    always_ff @(posedge clk_ex or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            dmem_req   <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (state_q == S_IDLE) begin
                if (count_q != '0) begin
                    state_q    <= S_REQ;
                    dmem_req   <= 1'b1;
                    dmem_addr  <= stq_addr_q[rd_ptr_q];
                    dmem_wdata <= stq_data_q[rd_ptr_q];
                end
            end else if (dmem_ack) begin
                if (count_q > ONE) begin
                    dmem_addr  <= stq_addr_q[rd_nxt];
                    dmem_wdata <= stq_data_q[rd_nxt];
                end else begin
                    dmem_req <= 1'b0;
                    state_q  <= S_IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: table-driven regfile vectors plus scoreboarded store-queue sequences.
module tb_writeback_unit;
    logic        clk_ex = 1'b0, n_reset = 1'b1;
    logic        ex_valid = 1'b0, reg_we = 1'b0, mem_we = 1'b0, dmem_ack = 1'b0;
    logic [7:0]  reg_id = '0, rd_id_a = '0, rd_id_b = '0;
    logic [31:0] reg_val = '0, mem_addr = '0, mem_val = '0;
    logic        ex_ready, dmem_req, stq_empty;
    logic [31:0] rd_val_a, rd_val_b, dmem_addr, dmem_wdata;

    int checks = 0, failures = 0, pops = 0;
    logic [63:0] sb [$];
    logic        hold = 1'b0;
    logic [63:0] held;

    typedef struct {
        logic        v, rw, c;
        logic [7:0]  id, ra, rb;
        logic [31:0] val, ea, eb;
    } vec_t;
    vec_t tbl [8];

    writeback_unit dut (
        .clk_ex(clk_ex), .n_reset(n_reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .reg_we(reg_we), .reg_id(reg_id), .reg_val(reg_val), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_val(mem_val), .rd_id_a(rd_id_a), .rd_id_b(rd_id_b),
        .rd_val_a(rd_val_a), .rd_val_b(rd_val_b), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .stq_empty(stq_empty)
    );

    always #5 clk_ex = ~clk_ex;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_ex);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        reg_we   = 1'b0;
        mem_we   = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        ex_valid = 1'b1;
        mem_we   = 1'b1;
        reg_we   = 1'b0;
        mem_addr = a;
        mem_val  = d;
        sb.push_back({a, d});
    endtask

    // Acks on the n-th consecutive cycle dmem_req is seen high.
    task automatic drain_one(input int n);
        int hi = 0;
        int t = 0;
        while (hi < n && t < 50) begin
            if (dmem_req) begin
                hi++;
                if (hi == n) dmem_ack = 1'b1;
            end else if (hi > 0) begin
                break;
            end
            step();
            dmem_ack = 1'b0;
            t++;
        end
        chk("req_cycles", 64'(hi), 64'(n));
    endtask

    always @(negedge clk_ex) begin
        if (!n_reset) begin
            hold = 1'b0;
        end else begin
            if (hold && dmem_req)
                chk("payload_stable", {dmem_addr, dmem_wdata}, held);
            if (dmem_req && dmem_ack) begin
                pops++;
                if (sb.size() == 0) chk("sb_underflow", {dmem_addr, dmem_wdata}, 64'hx);
                else chk("store_order", {dmem_addr, dmem_wdata}, sb.pop_front());
            end
            hold = dmem_req && !dmem_ack;
            held = {dmem_addr, dmem_wdata};
        end
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int hi, rises, p0;
        logic prev;
        tbl[0] = '{v:1, rw:1, c:0, id:8'h55, ra:8'h00, rb:8'h00, val:32'd123,        ea:32'd0,          eb:32'd0};
        tbl[1] = '{v:1, rw:1, c:1, id:8'h10, ra:8'h55, rb:8'h55, val:32'hdeadbeef,   ea:32'd123,        eb:32'd123};
        tbl[2] = '{v:1, rw:1, c:1, id:8'hff, ra:8'h10, rb:8'h55, val:32'd1,          ea:32'hdeadbeef,   eb:32'd123};
        tbl[3] = '{v:1, rw:1, c:1, id:8'h00, ra:8'hff, rb:8'h10, val:32'hffffffff,   ea:32'd1,          eb:32'hdeadbeef};
        tbl[4] = '{v:1, rw:1, c:1, id:8'h55, ra:8'h00, rb:8'hff, val:32'd456,        ea:32'hffffffff,   eb:32'd1};
        tbl[5] = '{v:1, rw:0, c:1, id:8'h10, ra:8'h55, rb:8'h10, val:32'd0,          ea:32'd456,        eb:32'hdeadbeef};
        tbl[6] = '{v:0, rw:1, c:1, id:8'h10, ra:8'h10, rb:8'h00, val:32'd777,        ea:32'hdeadbeef,   eb:32'hffffffff};
        tbl[7] = '{v:0, rw:0, c:1, id:8'h00, ra:8'h10, rb:8'h55, val:32'd0,          ea:32'hdeadbeef,   eb:32'd456};

        #1 n_reset = 1'b0;
        #2;
        chk("rst_req", 64'(dmem_req), 64'd0);
        chk("rst_addr", 64'(dmem_addr), 64'd0);
        chk("rst_wdata", 64'(dmem_wdata), 64'd0);
        chk("rst_empty", 64'(stq_empty), 64'd1);
        chk("rst_ready", 64'(ex_ready), 64'd1);
        step();
        step();
        n_reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step();
            ex_valid = tbl[i].v;
            reg_we   = tbl[i].rw;
            reg_id   = tbl[i].id;
            reg_val  = tbl[i].val;
            rd_id_a  = tbl[i].ra;
            rd_id_b  = tbl[i].rb;
            #2;
            if (tbl[i].c) begin
                chk($sformatf("rd_a[%0d]", i), 64'(rd_val_a), 64'(tbl[i].ea));
                chk($sformatf("rd_b[%0d]", i), 64'(rd_val_b), 64'(tbl[i].eb));
            end
            chk($sformatf("no_req[%0d]", i), 64'(dmem_req), 64'd0);
        end

        step();
        store(32'd567, 32'd999);
        step();
        idle();
        chk("req_after_push", 64'(dmem_req), 64'd0);
        chk("not_empty", 64'(stq_empty), 64'd0);
        step();
        chk("req_latency", 64'(dmem_req), 64'd1);
        drain_one(3);
        chk("single_done_req", 64'(dmem_req), 64'd0);
        chk("single_empty", 64'(stq_empty), 64'd1);

        for (int i = 0; i < 4; i++) begin
            step();
            store(32'h100 + i, 32'ha0 + i);
        end
        step();
        ex_valid = 1'b1;
        mem_we   = 1'b1;
        mem_addr = 32'h1ff;
        mem_val  = 32'h5ee;
        reg_we   = 1'b1;
        reg_id   = 8'h10;
        reg_val  = 32'h1111;
        #2 chk("full_ready", 64'(ex_ready), 64'd0);
        step();
        chk("full_ready_hold", 64'(ex_ready), 64'd0);
        chk("full_req", 64'(dmem_req), 64'd1);
        idle();
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("ready_after_pop", 64'(ex_ready), 64'd1);
        rd_id_a = 8'h10;
        #2 chk("ignored_reg_write", 64'(rd_val_a), 64'hdeadbeef);
        for (int i = 0; i < 3; i++) drain_one(1);
        chk("full_drained", 64'(stq_empty), 64'd1);
        chk("full_sb_empty", 64'(sb.size()), 64'd0);

        dmem_ack = 1'b1;
        hi = 0;
        rises = 0;
        prev = 1'b0;
        p0 = pops;
        for (int k = 0; k < 16; k++) begin
            step();
            if (dmem_req) hi++;
            if (dmem_req && !prev) rises++;
            prev = dmem_req;
            if (k < 6) store(32'h200 + k, 32'hb0 + k);
            else idle();
        end
        dmem_ack = 1'b0;
        chk("b2b_req_cycles", 64'(hi), 64'd6);
        chk("b2b_no_gaps", 64'(rises), 64'd1);
        chk("b2b_pops", 64'(pops - p0), 64'd6);
        chk("b2b_empty", 64'(stq_empty), 64'd1);

        for (int i = 0; i < 3; i++) begin
            step();
            store(32'h300 + i, 32'hc0 + i);
        end
        step();
        idle();
        step();
        chk("pre_rst_req", 64'(dmem_req), 64'd1);
        #2 n_reset = 1'b0;
        #1;
        chk("mid_rst_req", 64'(dmem_req), 64'd0);
        chk("mid_rst_empty", 64'(stq_empty), 64'd1);
        chk("mid_rst_ready", 64'(ex_ready), 64'd1);
        chk("mid_rst_addr", 64'(dmem_addr), 64'd0);
        sb.delete();
        step();
        step();
        n_reset = 1'b1;
        step();
        step();
        chk("post_rst_req", 64'(dmem_req), 64'd0);
        chk("post_rst_empty", 64'(stq_empty), 64'd1);

        step();
        ex_valid = 1'b1;
        reg_we   = 1'b1;
        reg_id   = 8'h03;
        reg_val  = 32'd5;
        step();
        reg_val = 32'd7;
        rd_id_b = 8'h03;
`ifdef WB_BYPASS_EN
        #2 chk("bypass_same_cycle", 64'(rd_val_b), 64'd7);
`else
        #2 chk("nobypass_old", 64'(rd_val_b), 64'd5);
`endif
        step();
        idle();
        #2 chk("write_next_cycle", 64'(rd_val_b), 64'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
